// File: rtl/spi_master_pkg.sv
// Shared types and frame layout for the SPI master.
// Frame is {CMD, addr, data_in}, MSB first.
package spi_master_pkg;

  localparam int FRAME_W  = 24;
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [3:0]  cmd,
    input logic [3:0]  addr,
    input logic [15:0] data
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CMD_MSB:CMD_LSB]   = cmd;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: toggles every CLK_DIV cycles while enabled,
// with single-cycle strobes on the cycle SCK rises or falls.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt;
  logic       tick;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// 24-bit SPI mode-0 master, single or continuous frames.
// Define SPI_LOOPBACK_EN to receive the internal MOSI instead of MISO.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'h0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                busy,
  input  logic [3:0]          addr,
  input  logic [15:0]         data_in,
  input  logic                spi_miso,
  input  logic                spi_send,
  output logic                spi_cs,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic [FRAME_W-1:0]  data_out,
  output logic                send_done
);

  state_t state, state_nx;

  logic               prev_send;
  logic               start;
  logic [8:0]         cnt;
  logic [4:0]         nfall;
  logic               gap;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic               rx_bit;
  logic               sck_en;
  logic               cs_low;
  logic               rise;
  logic               fall;
  logic               cnt_end;
  logic               setup_end;
  logic               last_fall;
  logic               enter_setup;
  logic               enter_done;

  assign start     = spi_send && !prev_send;
  assign cnt_end   = cnt == 9'(CLK_DIV - 1);
  // back-to-back frames keep CS high for the first CLK_DIV-1 SETUP cycles
  assign setup_end = gap ? (cnt == 9'(2 * CLK_DIV - 2)) : cnt_end;
  assign last_fall = fall && (nfall == 5'd23);

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = spi_mosi;
`else
  assign rx_bit = spi_miso;
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (sck_en),
    .sck   (spi_sck),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sck_en   = 1'b0;
    cs_low   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SETUP;
      end
      SETUP: begin
        cs_low = !(gap && (cnt < 9'(CLK_DIV - 1)));
        if (setup_end) state_nx = SHIFT;
      end
      SHIFT: begin
        cs_low = 1'b1;
        sck_en = 1'b1;
        if (last_fall) state_nx = HOLD;
      end
      HOLD: begin
        cs_low = 1'b1;
        if (cnt_end) state_nx = DONE;
      end
      DONE: begin
        state_nx = busy ? SETUP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign spi_cs      = !cs_low;
  assign spi_mosi    = tx_sr[FRAME_W-1];
  assign enter_setup = (state_nx == SETUP) && (state != SETUP);
  assign enter_done  = (state_nx == DONE) && (state != DONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_send <= 1'b1;
      cnt       <= '0;
      nfall     <= '0;
      gap       <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      data_out  <= '0;
      send_done <= 1'b0;
    end else begin
      prev_send <= spi_send;
      if (state_nx != state)
        cnt <= '0;
      else if (state == SETUP || state == HOLD)
        cnt <= cnt + 9'd1;
      if (rise)
        rx_sr <= {rx_sr[FRAME_W-2:0], rx_bit};
      if (fall) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
        nfall <= nfall + 5'd1;
      end
      if (enter_setup) begin
        tx_sr     <= build_frame(CMD, addr, data_in);
        gap       <= (state == DONE);
        nfall     <= '0;
        send_done <= 1'b0;
      end
      if (enter_done) begin
        data_out  <= rx_sr;
        send_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single frames plus
// hand sequences for continuous mode and mid-frame reset.
module tb_spi_master;

  localparam int D = 4;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        busy      = 1'b0;
  logic [3:0]  addr      = '0;
  logic [15:0] data_in   = '0;
  logic        spi_miso  = 1'b0;
  logic        spi_send  = 1'b0;
  logic        spi_cs;
  logic        spi_sck;
  logic        spi_mosi;
  logic [23:0] data_out;
  logic        send_done;

  int checks   = 0;
  int failures = 0;

  spi_master #(
    .CLK_DIV (D),
    .CMD     (4'h0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .busy      (busy),
    .addr      (addr),
    .data_in   (data_in),
    .spi_miso  (spi_miso),
    .spi_send  (spi_send),
    .spi_cs    (spi_cs),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .data_out  (data_out),
    .send_done (send_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    logic [23:0] miso;
    logic        pulse;
    logic        mut;
    logic [23:0] mosi;
  } vec_t;

  vec_t vt[4];

  task automatic run_frame(input vec_t v, output logic [23:0] cap,
                           output int rises, output int low,
                           output logic sd_bad, output logic ok);
    logic last;
    int   idx;
    addr     = v.a;
    data_in  = v.d;
    spi_miso = v.miso[23];
    spi_send = 1'b0;
    @(posedge sys_clk);
    #1 spi_send = 1'b1;
    cap = '0; rises = 0; low = 0; sd_bad = 1'b0; ok = 1'b0;
    last = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (!spi_cs && send_done) sd_bad = 1'b1;
      if (!spi_cs) low++;
      if (spi_sck && !last) begin
        cap = {cap[22:0], spi_mosi};
        rises++;
        if (rises < 24) begin
          idx = 23 - rises;
          spi_miso = v.miso[idx];
        end
        if (v.pulse && rises == 12) spi_send = 1'b0;
        if (v.pulse && rises == 14) spi_send = 1'b1;
        if (v.mut && rises == 5) begin
          addr    = ~v.a;
          data_in = ~v.d;
        end
      end
      last = spi_sck;
      if (low > 0 && spi_cs && send_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [23:0] cap;
    logic [23:0] exp_dout;
    logic [23:0] cc[2];
    logic        sd_bad, ok, lastcs, lastsck;
    int          rises, low, extra, f, ends, gap, rs;

    vt[0] = '{4'h4, 16'hE6B6, 24'h000000, 1'b0, 1'b0, 24'h04E6B6};
    vt[1] = '{4'h4, 16'hE6B6, 24'hFFFFFF, 1'b0, 1'b0, 24'h04E6B6};
    vt[2] = '{4'hA, 16'h5A5A, 24'h123456, 1'b1, 1'b0, 24'h0A5A5A};
    vt[3] = '{4'hF, 16'hFFFF, 24'hA5C3E1, 1'b0, 1'b1, 24'h0FFFFF};

    #20 sys_rst_n = 1'b0;
    #10;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_done", 32'(send_done), 32'd0);
    #10 sys_rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
`ifdef SPI_LOOPBACK_EN
      exp_dout = vt[i].mosi;
`else
      exp_dout = vt[i].miso;
`endif
      run_frame(vt[i], cap, rises, low, sd_bad, ok);
      check($sformatf("v%0d_finish", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_mosi", i), 32'(cap), 32'(vt[i].mosi));
      check($sformatf("v%0d_sck_pulses", i), 32'(rises), 32'd24);
      check($sformatf("v%0d_cs_low_cycles", i), 32'(low), 32'(50 * D));
      check($sformatf("v%0d_done_in_frame", i), 32'(sd_bad), 32'd0);
      check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(exp_dout));
      extra = 0;
      repeat (40) begin
        @(negedge sys_clk);
        if (!spi_cs || spi_sck) extra++;
      end
      check($sformatf("v%0d_no_retrigger", i), 32'(extra), 32'd0);
      check($sformatf("v%0d_done_held", i), 32'(send_done), 32'd1);
    end

    // continuous mode with a mid-frame data change
    busy     = 1'b1;
    addr     = 4'h4;
    data_in  = 16'hE6B6;
    spi_miso = 1'b0;
    spi_send = 1'b0;
    @(posedge sys_clk);
    #1 spi_send = 1'b1;
    f = -1; ends = 0; gap = 0; rs = 0;
    lastcs = 1'b1; lastsck = 1'b0;
    cc[0] = '0; cc[1] = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (lastcs && !spi_cs) begin
        f++;
        rs = 0;
      end
      if (!lastcs && spi_cs) begin
        ends++;
        if (ends == 2) busy = 1'b0;
      end
      if (spi_cs && ends == 1 && f == 0) gap++;
      if (spi_sck && !lastsck && f >= 0 && f < 2) begin
        cc[f] = {cc[f][22:0], spi_mosi};
        rs++;
        if (f == 0 && rs == 10) data_in = 16'h1234;
      end
      lastcs  = spi_cs;
      lastsck = spi_sck;
      if (ends == 2) break;
    end
    check("cont_frames", 32'(ends), 32'd2);
    check("cont_mosi0", 32'(cc[0]), 32'h04E6B6);
    check("cont_mosi1", 32'(cc[1]), 32'h041234);
    check("cont_gap_ge_div", 32'(gap >= D), 32'd1);
    extra = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!spi_cs) extra++;
    end
    check("cont_stops", 32'(extra), 32'd0);
    check("cont_done_held", 32'(send_done), 32'd1);

    // reset during a frame
    busy     = 1'b0;
    addr     = 4'h4;
    data_in  = 16'hE6B6;
    spi_send = 1'b0;
    @(posedge sys_clk);
    #1 spi_send = 1'b1;
    rs = 0; lastsck = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (spi_sck && !lastsck) rs++;
      lastsck = spi_sck;
      if (rs == 10) break;
    end
    check("rst_mid_reached", 32'(rs), 32'd10);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(spi_cs), 32'd1);
    check("rst_mid_sck", 32'(spi_sck), 32'd0);
    check("rst_mid_done", 32'(send_done), 32'd0);
    check("rst_mid_dout", 32'(data_out), 32'd0);
    #20 sys_rst_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!spi_cs || send_done) extra++;
    end
    check("rst_no_restart", 32'(extra), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
